// File: rtl/regfile_pkg.sv
// Shared types for the multi-port, double-word capable register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    WM_SINGLE = 2'd0,
    WM_DOUBLE = 2'd1,
    WM_LINK   = 2'd2,
    WM_RSVD   = 2'd3
  } wr_mode_e;

  typedef enum logic [1:0] {
    EXC_NONE   = 2'd0,
    EXC_ODD_DW = 2'd1,
    EXC_PC_WR  = 2'd2,
    EXC_DW_PC  = 2'd3
  } exc_code_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DW_HI = 1'b1
  } dw_state_e;

endpackage

// File: rtl/regfile_wr_ctrl.sv
// Write-port control: handshake, double-word sequencing, legality checks and exceptions.
// Produces one combinational commit bus shared by the storage array and read bypass.
module regfile_wr_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned AW       = 4,
  parameter int unsigned PC_REG   = 15,
  parameter int unsigned LINK_REG = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              wr_valid,
  input  logic [1:0]        wr_mode,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data_lo,
  input  logic [DATA_W-1:0] wr_data_hi,
  input  logic [DATA_W-1:0] return_addr,
  output logic              wr_ready,
  output logic              commit_we_c,
  output logic [AW-1:0]     commit_addr_c,
  output logic [DATA_W-1:0] commit_data_c,
  output logic              exception,
  output logic [1:0]        exc_code
);

  localparam logic [AW-1:0] PC_A   = AW'(PC_REG);
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  dw_state_e         state, state_n;
  logic [AW-1:0]     hi_addr, hi_addr_n;
  logic [DATA_W-1:0] hi_data, hi_data_n;
  logic              exc_n;
  exc_code_e         code, code_n;
  logic              accept;
  logic [AW-1:0]     pair_addr;

  assign accept    = wr_valid && (state == IDLE) && !stall;
  assign pair_addr = {wr_addr[AW-1:1], 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hi_addr   <= '0;
      hi_data   <= '0;
      exception <= 1'b0;
      code      <= EXC_NONE;
      wr_ready  <= 1'b1;
    end else begin
      state     <= state_n;
      hi_addr   <= hi_addr_n;
      hi_data   <= hi_data_n;
      exception <= exc_n;
      code      <= code_n;
      wr_ready  <= (state_n == IDLE);
    end
  end

  always_comb begin
    state_n       = state;
    hi_addr_n     = hi_addr;
    hi_data_n     = hi_data;
    exc_n         = 1'b0;
    code_n        = code;
    commit_we_c   = 1'b0;
    commit_addr_c = wr_addr;
    commit_data_c = wr_data_lo;
    case (state)
      IDLE: begin
        if (accept) begin
          case (wr_mode_e'(wr_mode))
            WM_LINK: begin
              commit_we_c   = 1'b1;
              commit_addr_c = LINK_A;
              commit_data_c = return_addr;
            end
            WM_DOUBLE: begin
              if (wr_addr[0]) begin
                exc_n  = 1'b1;
                code_n = EXC_ODD_DW;
              end else if (pair_addr == PC_A) begin
                exc_n  = 1'b1;
                code_n = EXC_DW_PC;
              end else begin
                commit_we_c = 1'b1;
                hi_addr_n   = pair_addr;
                hi_data_n   = wr_data_hi;
                state_n     = DW_HI;
              end
            end
            default: begin
              // Reserved mode behaves as a single write.
              if (wr_addr == PC_A) begin
                exc_n  = 1'b1;
                code_n = EXC_PC_WR;
              end else begin
                commit_we_c = 1'b1;
              end
            end
          endcase
        end
      end
      DW_HI: begin
        if (!stall) begin
          commit_we_c   = 1'b1;
          commit_addr_c = hi_addr;
          commit_data_c = hi_data;
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign exc_code = code;

endmodule

// File: rtl/regfile_mp_dw.sv
// Register file with NUM_RD synchronous read ports, write-to-read bypass and one
// handshaked write port supporting single, double-word and link writes.
module regfile_mp_dw
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned PC_REG   = 15,
  parameter int unsigned LINK_REG = 14,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic                     rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [1:0]               wr_mode,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data_lo,
  input  logic [DATA_W-1:0]        wr_data_hi,
  input  logic [DATA_W-1:0]        return_addr,
  output logic                     exception,
  output logic [1:0]               exc_code
);

  logic              commit_we_c;
  logic [AW-1:0]     commit_addr_c;
  logic [DATA_W-1:0] commit_data_c;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_q [NUM_RD];
  logic [DATA_W-1:0] rd_nxt_c [NUM_RD];

  regfile_wr_ctrl #(
    .DATA_W  (DATA_W),
    .AW      (AW),
    .PC_REG  (PC_REG),
    .LINK_REG(LINK_REG)
  ) u_wr_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .wr_valid     (wr_valid),
    .wr_mode      (wr_mode),
    .wr_addr      (wr_addr),
    .wr_data_lo   (wr_data_lo),
    .wr_data_hi   (wr_data_hi),
    .return_addr  (return_addr),
    .wr_ready     (wr_ready),
    .commit_we_c  (commit_we_c),
    .commit_addr_c(commit_addr_c),
    .commit_data_c(commit_data_c),
    .exception    (exception),
    .exc_code     (exc_code)
  );

  // Storage array; reset clears every register including the PC slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_we_c) begin
      regs[commit_addr_c] <= commit_data_c;
    end
  end

  // Per-port read select with bypass of the write committing on the same edge.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] ra_c;
    assign ra_c        = rd_addr[k*AW +: AW];
    assign rd_nxt_c[k] = (commit_we_c && (commit_addr_c == ra_c)) ? commit_data_c : regs[ra_c];
    assign rd_data[k*DATA_W +: DATA_W] = rd_q[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_RD; k++) rd_q[k] <= '0;
    end else if (rd_en && !stall) begin
      for (int k = 0; k < NUM_RD; k++) rd_q[k] <= rd_nxt_c[k];
    end
  end

endmodule
